// File: rtl/ctrl_seg.sv
// ctrl_seg: arming controller for a six-zone alarm.
// Sequences the disarmed / exit-delay / armed / entry-delay / alarm /
// maintenance states, checks the keypad code, and drives siren, lights
// and the armed indicator. The outputs are decoded from registered state.
module ctrl_seg #(
    parameter int         EXIT_CYC  = 16,
    parameter int         ENTRY_CYC = 8,
    parameter int         SIREN_CYC = 32,
    parameter logic [3:0] CODE      = 4'hA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       M,
    input  logic [5:0] S,
    input  logic       arm,
    input  logic [3:0] code,
    input  logic       code_vld,
    output logic       siren,
    output logic       light,
    output logic       armed,
    output logic       arm_err,
    output logic [2:0] state,
    output logic [5:0] zones
);

    typedef enum logic [2:0] {
        DESARMADO = 3'd0,
        SALIDA    = 3'd1,
        ARMADO    = 3'd2,
        ENTRADA   = 3'd3,
        ALARMA    = 3'd4,
        MANT      = 3'd5
    } st_t;

    // Timers count down to zero, so they are loaded with length-1.
    localparam logic [7:0] EXIT_LD  = 8'(EXIT_CYC - 1);
    localparam logic [7:0] ENTRY_LD = 8'(ENTRY_CYC - 1);
    localparam logic [7:0] SIREN_LD = 8'(SIREN_CYC);

    st_t        st;
    logic [7:0] timer;
    logic [7:0] siren_cnt;
    logic [1:0] fails;

    logic       code_ok;
    logic       code_bad;
    logic       fail_lim;
    logic [1:0] fails_inc;
    logic [5:0] open_z;
    logic       inner_trip;

    assign code_ok    = code_vld && (code == CODE);
    assign code_bad   = code_vld && (code != CODE);
    // The wrong code that takes the counter to 3 is the one that alarms.
    assign fail_lim   = code_bad && (fails == 2'd2);
    assign fails_inc  = (code_bad && fails != 2'd3) ? fails + 2'd1 : fails;
    assign open_z     = ~S;
    assign inner_trip = |open_z[5:1];

    // Main sequencer: a valid code beats the fail limit, which beats
    // sensor trips and timer expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= DESARMADO;
            timer     <= '0;
            siren_cnt <= '0;
            fails     <= '0;
            zones     <= '0;
            arm_err   <= 1'b0;
        end else begin
            arm_err <= 1'b0;
            case (st)
                DESARMADO: begin
                    if (M) begin
                        st <= MANT;
                    end else if (arm) begin
                        if (S == 6'h3F) begin
                            st    <= SALIDA;
                            timer <= EXIT_LD;
                            zones <= '0;
                        end else begin
                            arm_err <= 1'b1;
                        end
                    end
                end
                MANT: begin
                    if (!M) st <= DESARMADO;
                end
                SALIDA: begin
                    if (code_ok) begin
                        st    <= DESARMADO;
                        fails <= '0;
                    end else if (fail_lim) begin
                        st        <= ALARMA;
                        siren_cnt <= SIREN_LD;
                        fails     <= 2'd3;
                    end else begin
                        fails <= fails_inc;
                        if (timer == 8'd0) st <= ARMADO;
                        else               timer <= timer - 8'd1;
                    end
                end
                ARMADO: begin
                    if (code_ok) begin
                        st    <= DESARMADO;
                        fails <= '0;
                    end else if (fail_lim) begin
                        st        <= ALARMA;
                        siren_cnt <= SIREN_LD;
                        fails     <= 2'd3;
                    end else begin
                        fails <= fails_inc;
                        if (inner_trip) begin
                            st        <= ALARMA;
                            siren_cnt <= SIREN_LD;
                            zones     <= zones | open_z;
                        end else if (open_z[0]) begin
                            st    <= ENTRADA;
                            timer <= ENTRY_LD;
                            zones <= zones | open_z;
                        end
                    end
                end
                ENTRADA: begin
                    zones <= zones | open_z;
                    if (code_ok) begin
                        st    <= DESARMADO;
                        fails <= '0;
                    end else if (fail_lim) begin
                        st        <= ALARMA;
                        siren_cnt <= SIREN_LD;
                        fails     <= 2'd3;
                    end else begin
                        fails <= fails_inc;
                        if (inner_trip || timer == 8'd0) begin
                            st        <= ALARMA;
                            siren_cnt <= SIREN_LD;
                        end else begin
                            timer <= timer - 8'd1;
                        end
                    end
                end
                ALARMA: begin
                    zones <= zones | open_z;
                    if (code_ok) begin
                        st    <= DESARMADO;
                        fails <= '0;
                    end else begin
                        fails <= fails_inc;
                        if (siren_cnt != 8'd0) siren_cnt <= siren_cnt - 8'd1;
                    end
                end
                default: st <= DESARMADO;
            endcase
        end
    end

    // Moore decode; reset clears the registers, so outputs drop at once.
    always_comb begin
        state = st;
        armed = (st == ARMADO) || (st == ENTRADA) || (st == ALARMA);
        light = (st == ENTRADA) || (st == ALARMA);
        siren = (st == ALARMA) && (siren_cnt != 8'd0);
    end

endmodule

// File: tb/tb_ctrl_seg.sv
// Scoreboard bench for ctrl_seg: the driver steps an event/deadline model
// and queues expected outputs; the monitor pops and compares each cycle.
module tb_ctrl_seg;

    localparam int         EXIT_CYC  = 16;
    localparam int         ENTRY_CYC = 8;
    localparam int         SIREN_CYC = 32;
    localparam logic [3:0] CODE      = 4'hA;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       M = 1'b0;
    logic [5:0] S = 6'h3F;
    logic       arm = 1'b0;
    logic [3:0] code = 4'h0;
    logic       code_vld = 1'b0;
    logic       siren, light, armed, arm_err;
    logic [2:0] state;
    logic [5:0] zones;

    ctrl_seg #(
        .EXIT_CYC (EXIT_CYC),
        .ENTRY_CYC(ENTRY_CYC),
        .SIREN_CYC(SIREN_CYC),
        .CODE     (CODE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .M       (M),
        .S       (S),
        .arm     (arm),
        .code    (code),
        .code_vld(code_vld),
        .siren   (siren),
        .light   (light),
        .armed   (armed),
        .arm_err (arm_err),
        .state   (state),
        .zones   (zones)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] state;
        logic       siren;
        logic       light;
        logic       armed;
        logic       arm_err;
        logic [5:0] zones;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   vecs = 0;
    int   errs = 0;

    // Reference model: mode number, absolute deadline edge, alarm start edge.
    int         ms, deadline, fails, alarm_t, c;
    logic [5:0] mz;

    task automatic check(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, c);
        end
    endtask

    task automatic model_reset();
        ms = 0; deadline = 0; fails = 0; alarm_t = -1000; c = 0; mz = 6'h00;
    endtask

    task automatic go_alarm();
        ms = 4;
        alarm_t = c;
    endtask

    task automatic mstep(input logic m_i, input logic [5:0] s_i, input logic a_i,
                         input logic [3:0] c_i, input logic v_i);
        logic [5:0] op;
        logic       vc, wc, err;
        exp_t       e;
        c++;
        op  = ~s_i;
        vc  = v_i && (c_i == CODE);
        wc  = v_i && (c_i != CODE);
        err = 1'b0;
        if (ms == 3 || ms == 4) mz = mz | op;
        case (ms)
            0: begin
                if (m_i) ms = 5;
                else if (a_i) begin
                    if (s_i == 6'h3F) begin ms = 1; deadline = c + EXIT_CYC; mz = 6'h00; end
                    else err = 1'b1;
                end
            end
            5: if (!m_i) ms = 0;
            1, 2, 3: begin
                if (vc) begin
                    ms = 0; fails = 0;
                end else if (wc && fails == 2) begin
                    fails = 3; go_alarm();
                end else begin
                    if (wc) fails = fails + 1;
                    if (ms == 1) begin
                        if (c == deadline) ms = 2;
                    end else if (ms == 2) begin
                        if (op[5:1] != 0) begin mz = mz | op; go_alarm(); end
                        else if (op[0]) begin mz = mz | op; ms = 3; deadline = c + ENTRY_CYC; end
                    end else begin
                        if (op[5:1] != 0 || c == deadline) go_alarm();
                    end
                end
            end
            4: begin
                if (vc) begin ms = 0; fails = 0; end
                else if (wc && fails < 3) fails = fails + 1;
            end
            default: ;
        endcase
        e.state   = 3'(ms);
        e.siren   = (ms == 4) && ((c - alarm_t) < SIREN_CYC);
        e.light   = (ms == 3) || (ms == 4);
        e.armed   = (ms == 2) || (ms == 3) || (ms == 4);
        e.arm_err = err;
        e.zones   = mz;
        q.push_back(e);
    endtask

    task automatic cyc(input logic m_i, input logic [5:0] s_i, input logic a_i,
                       input logic [3:0] c_i, input logic v_i);
        @(negedge clk);
        M = m_i; S = s_i; arm = a_i; code = c_i; code_vld = v_i;
        mstep(m_i, s_i, a_i, c_i, v_i);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 6'h3F, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic key(input logic [3:0] k);
        cyc(1'b0, 6'h3F, 1'b0, k, 1'b1);
    endtask

    task automatic arm_and_wait();
        cyc(1'b0, 6'h3F, 1'b1, 4'h0, 1'b0);
        idle(EXIT_CYC);
    endtask

    // Monitor: one expected record per clock edge.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            me = q.pop_front();
            check("state",   int'(state),   int'(me.state));
            check("siren",   int'(siren),   int'(me.siren));
            check("light",   int'(light),   int'(me.light));
            check("armed",   int'(armed),   int'(me.armed));
            check("arm_err", int'(arm_err), int'(me.arm_err));
            check("zones",   int'(zones),   int'(me.zones));
        end
    end

    initial begin
        logic mlev;
        logic [5:0] rs;
        model_reset();
        #1;
        check("rst_state", int'(state), 0);
        check("rst_siren", int'(siren), 0);
        check("rst_armed", int'(armed), 0);
        check("rst_light", int'(light), 0);
        check("rst_err",   int'(arm_err), 0);
        check("rst_zones", int'(zones), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Arm and exit-delay expiry
        arm_and_wait();
        idle(3);
        // Door trip, entry delay, then disarm
        cyc(1'b0, 6'h3E, 1'b0, 4'h0, 1'b0);
        idle(4);
        key(CODE);
        idle(2);
        // Entry expiry into alarm, full siren, then disarm
        arm_and_wait();
        cyc(1'b0, 6'h3E, 1'b0, 4'h0, 1'b0);
        idle(ENTRY_CYC + SIREN_CYC + 4);
        key(CODE);
        idle(2);
        // Intrusion on an inner zone
        arm_and_wait();
        cyc(1'b0, 6'h1F, 1'b0, 4'h0, 1'b0);
        idle(3);
        key(CODE);
        // Three wrong codes while armed
        arm_and_wait();
        key(4'h3); idle(2);
        key(4'h3); idle(2);
        key(4'h3); idle(3);
        key(CODE);
        idle(2);
        // Arm rejection, maintenance priority, M ignored while armed
        cyc(1'b0, 6'h3B, 1'b1, 4'h0, 1'b0);
        idle(2);
        cyc(1'b1, 6'h3F, 1'b1, 4'h0, 1'b0);
        repeat (3) cyc(1'b1, 6'h3F, 1'b0, 4'h0, 1'b0);
        idle(2);
        arm_and_wait();
        repeat (5) cyc(1'b1, 6'h3F, 1'b0, 4'h0, 1'b0);
        key(CODE);
        idle(2);

        // Asynchronous reset while the siren is sounding
        arm_and_wait();
        cyc(1'b0, 6'h1F, 1'b0, 4'h0, 1'b0);
        idle(5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_state", int'(state), 0);
        check("async_siren", int'(siren), 0);
        check("async_zones", int'(zones), 0);
        check("async_armed", int'(armed), 0);
        check("async_light", int'(light), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Randomized traffic
        mlev = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) mlev = ~mlev;
            rs = 6'h3F;
            if ($urandom_range(0, 39) == 0) rs = 6'($urandom);
            cyc(mlev, rs, ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 1) == 1) ? CODE : 4'($urandom),
                ($urandom_range(0, 19) == 0));
        end
        idle(2);
        @(posedge clk);
        #2;
        check("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
